// File: rtl/mitm_pkg.sv
// mitm_pkg
// Shared definitions for the MITM chunk sequencer slice:
//   - opcode constants carried in the top bits of the command chunk
//   - state encodings for the top sequencer and the chunk requester
//   - default command / data / opcode sizes
package mitm_pkg;

    localparam int DEF_CMD_SIZE     = 9;
    localparam int DEF_DATA_SIZE    = 8;
    localparam int DEF_OPCODE_WIDTH = 2;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_ERASE = 2'b11;

    // Top-level transaction sequencing. SEQ_CMD and SEQ_DATA cover the
    // REQ/WAIT_LO/WAIT_HI handshake, which the chunk requester runs.
    typedef enum logic [2:0] {
        SEQ_IDLE     = 3'd0,
        SEQ_CMD      = 3'd1,
        SEQ_DECODE   = 3'd2,
        SEQ_DATA     = 3'd3,
        SEQ_FIN      = 3'd4,
        SEQ_WAIT_END = 3'd5
    } seq_state_t;

    // Per-chunk handshake with bus control.
    typedef enum logic [1:0] {
        REQ_IDLE    = 2'd0,
        REQ_PULSE   = 2'd1,
        REQ_WAIT_LO = 2'd2,
        REQ_WAIT_HI = 2'd3
    } req_state_t;

endpackage

// File: rtl/mitm_chunk_sequencer_if.sv
// mitm_chunk_sequencer_if
// Bundle between the MITM sequencer and the SPI bus control block.
//   master modport (sequencer): drives chunk commands and fake data,
//                               reads bus status and captured chunks.
//   slave modport (bus control): the mirror image.
// Chunk data is left-aligned, MSB-first, in a BUF_SIZE-wide buffer.
interface mitm_chunk_sequencer_if #(
    parameter int BUF_SIZE         = 9,
    parameter int CHUNK_SIZE_WIDTH = $clog2(BUF_SIZE + 1)
);
    logic                        comm_active;
    logic                        bus_ready;
    logic [BUF_SIZE-1:0]         real_mosi_data;
    logic [BUF_SIZE-1:0]         real_miso_data;
    logic                        cmd_next_chunk;
    logic                        cmd_finish;
    logic [CHUNK_SIZE_WIDTH-1:0] next_chunk_size;
    logic                        fake_miso_select;
    logic                        fake_mosi_select;
    logic [BUF_SIZE-1:0]         fake_miso_data;
    logic [BUF_SIZE-1:0]         fake_mosi_data;

    modport master (
        input  comm_active, bus_ready, real_mosi_data, real_miso_data,
        output cmd_next_chunk, cmd_finish, next_chunk_size,
               fake_miso_select, fake_mosi_select, fake_miso_data, fake_mosi_data
    );

    modport slave (
        output comm_active, bus_ready, real_mosi_data, real_miso_data,
        input  cmd_next_chunk, cmd_finish, next_chunk_size,
               fake_miso_select, fake_mosi_select, fake_miso_data, fake_mosi_data
    );
endinterface

// File: rtl/mitm_chunk_sequencer_chunk_requester.sv
// chunk_requester
// Runs one chunk handshake with bus control:
//   go (1 cycle, with size) -> REQ pulse -> wait bus_ready low -> wait high.
// Ports:
//   sys_clk, rst      clock, synchronous active-high reset
//   go, size          start a request of 'size' bits
//   bus_ready         bus control idle / chunk captured
//   comm_active       bus transaction in progress; low aborts the request
//   cmd_next_chunk    one-cycle request pulse
//   next_chunk_size   size of the current request, held until the next go
//   done              one cycle: captured chunk data is valid
//   abort             one cycle: comm_active fell while a request was open
module chunk_requester
    import mitm_pkg::*;
#(
    parameter int CHUNK_SIZE_WIDTH = 4
) (
    input  logic                        sys_clk,
    input  logic                        rst,
    input  logic                        go,
    input  logic [CHUNK_SIZE_WIDTH-1:0] size,
    input  logic                        bus_ready,
    input  logic                        comm_active,
    output logic                        cmd_next_chunk,
    output logic [CHUNK_SIZE_WIDTH-1:0] next_chunk_size,
    output logic                        done,
    output logic                        abort
);

    req_state_t                  state_q;
    req_state_t                  state_d;
    logic [CHUNK_SIZE_WIDTH-1:0] size_q;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q <= REQ_IDLE;
            size_q  <= '0;
        end else begin
            state_q <= state_d;
            if (go) begin
                size_q <= size;
            end
        end
    end

    // Abort wins over any bus_ready movement in the same cycle.
    always_comb begin
        state_d = state_q;
        if (state_q != REQ_IDLE && !comm_active) begin
            state_d = REQ_IDLE;
        end else begin
            case (state_q)
                REQ_IDLE:    if (go)         state_d = REQ_PULSE;
                REQ_PULSE:                   state_d = REQ_WAIT_LO;
                // bus_ready is still high for a cycle after the pulse;
                // only its fall marks the chunk as started.
                REQ_WAIT_LO: if (!bus_ready) state_d = REQ_WAIT_HI;
                REQ_WAIT_HI: if (bus_ready)  state_d = REQ_IDLE;
                default:                     state_d = REQ_IDLE;
            endcase
        end
    end

    always_comb begin
        cmd_next_chunk = (state_q == REQ_PULSE) && comm_active;
        done           = (state_q == REQ_WAIT_HI) && comm_active && bus_ready;
        abort          = (state_q != REQ_IDLE) && !comm_active;
    end

    assign next_chunk_size = size_q;

endmodule

// File: rtl/mitm_chunk_sequencer.sv
// mitm_chunk_sequencer
// MITM stage in front of the SPI bus control block. For each transaction
// it requests a command chunk, decodes opcode/address, then requests the
// data chunk. A READ of target_addr (with enable) gets fake_value on MISO.
// Optional macro MITM_WRITE_TAMPER_EN: a WRITE of target_addr (with enable)
// gets fake_value on MOSI; otherwise the MOSI fake path is tied to 0.
// Ports:
//   sys_clk, rst   clock, synchronous active-high reset
//   enable         substitution enable, sampled in DECODE
//   target_addr    address to tamper
//   fake_value     substitute data
//   bus            master side of mitm_chunk_sequencer_if (bus control link)
//   hit_count      substituted transactions, wraps at 255
//   last_data      real MISO data of the last READ
module mitm_chunk_sequencer
    import mitm_pkg::*;
#(
    parameter int BUF_SIZE         = 9,
    parameter int CHUNK_SIZE_WIDTH = $clog2(BUF_SIZE + 1),
    parameter int CMD_SIZE         = DEF_CMD_SIZE,
    parameter int OPCODE_WIDTH     = DEF_OPCODE_WIDTH,
    parameter int DATA_SIZE        = DEF_DATA_SIZE
) (
    input  logic                             sys_clk,
    input  logic                             rst,
    input  logic                             enable,
    input  logic [CMD_SIZE-OPCODE_WIDTH-1:0] target_addr,
    input  logic [DATA_SIZE-1:0]             fake_value,
    mitm_chunk_sequencer_if.master           bus,
    output logic [7:0]                       hit_count,
    output logic [DATA_SIZE-1:0]             last_data
);

    localparam int ADDR_W = CMD_SIZE - OPCODE_WIDTH;
    localparam logic [OPCODE_WIDTH-1:0] OPC_READ  = OPCODE_WIDTH'(OP_READ);
    localparam logic [OPCODE_WIDTH-1:0] OPC_WRITE = OPCODE_WIDTH'(OP_WRITE);

    function automatic logic [BUF_SIZE-1:0] align_data(input logic [DATA_SIZE-1:0] v);
        logic [BUF_SIZE-1:0] r;
        r = '0;
        r[BUF_SIZE-1 -: DATA_SIZE] = v;
        return r;
    endfunction

    seq_state_t state_q;
    seq_state_t state_d;

    logic                        req_go;
    logic [CHUNK_SIZE_WIDTH-1:0] req_size;
    logic                        req_done;
    logic                        req_abort;
    logic                        abort;

    logic [OPCODE_WIDTH-1:0] opcode;
    logic [ADDR_W-1:0]       addr;
    logic                    read_hit;
    logic                    write_hit;

    logic [OPCODE_WIDTH-1:0] opcode_q;
    logic                    miso_sel_q;
    logic [BUF_SIZE-1:0]     miso_data_q;
    logic [7:0]              hit_count_q;
    logic [DATA_SIZE-1:0]    last_data_q;

    // Low bits of the captured buffers carry nothing for the chunk sizes used.
    logic unused_bits;
    assign unused_bits = ^{bus.real_miso_data, bus.real_mosi_data};

    chunk_requester #(
        .CHUNK_SIZE_WIDTH(CHUNK_SIZE_WIDTH)
    ) u_req (
        .sys_clk        (sys_clk),
        .rst            (rst),
        .go             (req_go),
        .size           (req_size),
        .bus_ready      (bus.bus_ready),
        .comm_active    (bus.comm_active),
        .cmd_next_chunk (bus.cmd_next_chunk),
        .next_chunk_size(bus.next_chunk_size),
        .done           (req_done),
        .abort          (req_abort)
    );

    // SS dropping outside IDLE/WAIT_END abandons the transaction; bus
    // control has already cleared its own buffers.
    assign abort = req_abort ||
                   ((state_q != SEQ_IDLE) && (state_q != SEQ_WAIT_END) && !bus.comm_active);

    assign opcode   = bus.real_mosi_data[BUF_SIZE-1 -: OPCODE_WIDTH];
    assign addr     = bus.real_mosi_data[BUF_SIZE-1-OPCODE_WIDTH -: ADDR_W];
    assign read_hit = enable && (opcode == OPC_READ) && (addr == target_addr);
`ifdef MITM_WRITE_TAMPER_EN
    assign write_hit = enable && (opcode == OPC_WRITE) && (addr == target_addr);
`else
    assign write_hit = 1'b0;
`endif

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q <= SEQ_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = SEQ_IDLE;
        end else begin
            case (state_q)
                SEQ_IDLE:     if (bus.comm_active && bus.bus_ready) state_d = SEQ_CMD;
                SEQ_CMD:      if (req_done)                         state_d = SEQ_DECODE;
                SEQ_DECODE:                                         state_d = SEQ_DATA;
                SEQ_DATA:     if (req_done)                         state_d = SEQ_FIN;
                SEQ_FIN:                                            state_d = SEQ_WAIT_END;
                SEQ_WAIT_END: if (!bus.comm_active)                 state_d = SEQ_IDLE;
                default:                                            state_d = SEQ_IDLE;
            endcase
        end
    end

    always_comb begin
        req_go         = 1'b0;
        req_size       = CHUNK_SIZE_WIDTH'(DATA_SIZE);
        bus.cmd_finish = 1'b0;
        if (!abort) begin
            case (state_q)
                SEQ_IDLE: begin
                    req_go   = bus.comm_active && bus.bus_ready;
                    req_size = CHUNK_SIZE_WIDTH'(CMD_SIZE);
                end
                SEQ_DECODE: req_go         = 1'b1;
                SEQ_FIN:    bus.cmd_finish = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef MITM_WRITE_TAMPER_EN
    logic                mosi_sel_q;
    logic [BUF_SIZE-1:0] mosi_data_q;
`endif

    // Selects are registered in DECODE, i.e. before the data-chunk
    // request, so the data chunk never starts without them.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            opcode_q    <= '0;
            miso_sel_q  <= 1'b0;
            miso_data_q <= '0;
            hit_count_q <= '0;
            last_data_q <= '0;
`ifdef MITM_WRITE_TAMPER_EN
            mosi_sel_q  <= 1'b0;
            mosi_data_q <= '0;
`endif
        end else if (abort) begin
            miso_sel_q  <= 1'b0;
            miso_data_q <= '0;
`ifdef MITM_WRITE_TAMPER_EN
            mosi_sel_q  <= 1'b0;
            mosi_data_q <= '0;
`endif
        end else begin
            case (state_q)
                SEQ_DECODE: begin
                    opcode_q <= opcode;
                    if (read_hit) begin
                        miso_sel_q  <= 1'b1;
                        miso_data_q <= align_data(fake_value);
                    end
`ifdef MITM_WRITE_TAMPER_EN
                    if (write_hit) begin
                        mosi_sel_q  <= 1'b1;
                        mosi_data_q <= align_data(fake_value);
                    end
`endif
                    if (read_hit || write_hit) begin
                        hit_count_q <= hit_count_q + 8'd1;
                    end
                end
                SEQ_DATA: begin
                    // Real EEPROM value, kept even when MISO was faked.
                    if (req_done && opcode_q == OPC_READ) begin
                        last_data_q <= bus.real_miso_data[BUF_SIZE-1 -: DATA_SIZE];
                    end
                end
                SEQ_WAIT_END: begin
                    if (!bus.comm_active) begin
                        miso_sel_q <= 1'b0;
`ifdef MITM_WRITE_TAMPER_EN
                        mosi_sel_q <= 1'b0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.fake_miso_select = miso_sel_q;
    assign bus.fake_miso_data   = miso_data_q;
`ifdef MITM_WRITE_TAMPER_EN
    assign bus.fake_mosi_select = mosi_sel_q;
    assign bus.fake_mosi_data   = mosi_data_q;
`else
    assign bus.fake_mosi_select = 1'b0;
    assign bus.fake_mosi_data   = '0;
`endif
    assign hit_count = hit_count_q;
    assign last_data = last_data_q;

endmodule
